led_activity_meter: RTL and testbench



---
 rtl/led_activity_meter_if.sv | 22 ++
 rtl/led_activity_meter.sv | 154 +++++++++++++++
 tb/tb_led_activity_meter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/led_activity_meter_if.sv
// Front-panel bundle between the synth top level and led_activity_meter:
// voice status inputs toward the meter, LED banks and occupancy count back out.
interface led_activity_meter_if #(
    parameter int VOICES = 2
);
    logic [VOICES-1:0] keys_on;
    logic [VOICES-1:0] voice_free;
    logic [7:0]        gled;
    logic [16:0]       rled;
    logic [4:0]        busy_cnt;
    logic              steal;

    modport master (
        output keys_on, voice_free,
        input  gled, rled, busy_cnt, steal
    );

    modport slave (
        input  keys_on, voice_free,
        output gled, rled, busy_cnt, steal
    );
endinterface

// File: rtl/led_activity_meter.sv
// Front-panel LED driver: stretched per-voice key activity on the green bank,
// occupancy bar with peak hold/decay and a voice-steal lamp on the red bank.
module led_activity_meter #(
    parameter int VOICES     = 2,
    parameter int HOLD_TICKS = 1220,
    parameter int PEAK_TICKS = 6104
) (
    input  logic               sysclk,
    input  logic               reset1,
    led_activity_meter_if.slave bus
);

    if (VOICES < 1 || VOICES > 16) begin : g_bad_voices
        $error("led_activity_meter: VOICES must be in 1..16");
    end
    if (HOLD_TICKS < 2) begin : g_bad_hold
        $error("led_activity_meter: HOLD_TICKS must be >= 2");
    end
    if (PEAK_TICKS < 2) begin : g_bad_peak
        $error("led_activity_meter: PEAK_TICKS must be >= 2");
    end

    localparam int HW = $clog2(HOLD_TICKS);
    localparam int PW = $clog2(PEAK_TICKS);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS - 1);
    localparam logic [PW-1:0] PEAK_LOAD = PW'(PEAK_TICKS - 1);

    typedef enum logic {IDLE, HOLD} peak_state_t;

    logic [VOICES-1:0] keys_m, keys_s, keys_p;
    logic [VOICES-1:0] free_m, free_s;
    logic [VOICES-1:0] rise;
    logic [HW-1:0]     hold [VOICES];
    logic [HW-1:0]     steal_cnt;
    logic [7:0]        gled_q, gled_next;
    logic [16:0]       rled_q;
    logic [15:0]       bar_next;
    logic [4:0]        busy_q;
    logic [4:0]        peak;
    logic [PW-1:0]     pt;
    peak_state_t       state;
    logic              steal_now;
    logic              steal_next;

    function automatic logic [4:0] busy_count(input logic [VOICES-1:0] free);
        logic [4:0] n;
        n = '0;
        for (int v = 0; v < VOICES; v++) begin
            n = n + {4'd0, ~free[v]};
        end
        return n;
    endfunction

    // Stage: two-flop synchronizers plus the previous-sample register for edge detect
    always_ff @(posedge sysclk or negedge reset1) begin
        if (!reset1) begin
            keys_m <= '0;
            keys_s <= '0;
            keys_p <= '0;
            free_m <= '1;
            free_s <= '1;
        end else begin
            keys_m <= bus.keys_on;
            keys_s <= keys_m;
            keys_p <= keys_s;
            free_m <= bus.voice_free;
            free_s <= free_m;
        end
    end

    assign rise       = keys_s & ~keys_p;
    assign steal_now  = (|rise) && (busy_q == 5'(VOICES));
    assign steal_next = steal_now || (steal_cnt != '0);

    always_comb begin
        gled_next = '0;
        for (int v = 0; v < VOICES && v < 8; v++) begin
            gled_next[v] = keys_s[v] | rise[v] | (hold[v] != '0);
        end
    end

    always_comb begin
        bar_next = '0;
        for (int i = 1; i <= 16; i++) begin
            bar_next[i-1] = (5'(i) <= busy_q) || (5'(i) == peak);
        end
    end

    // Stage: per-voice hold stretchers and green output register
    always_ff @(posedge sysclk or negedge reset1) begin
        if (!reset1) begin
            for (int v = 0; v < VOICES; v++) begin
                hold[v] <= '0;
            end
            gled_q <= '0;
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (rise[v]) begin
                    hold[v] <= HOLD_LOAD;
                end else if (hold[v] != '0) begin
                    hold[v] <= hold[v] - HW'(1);
                end
            end
            gled_q <= gled_next;
        end
    end

    // Stage: occupancy count, peak tracker, steal stretcher and red output register
    always_ff @(posedge sysclk or negedge reset1) begin
        if (!reset1) begin
            busy_q    <= '0;
            peak      <= '0;
            pt        <= '0;
            state     <= IDLE;
            steal_cnt <= '0;
            rled_q    <= '0;
        end else begin
            busy_q <= busy_count(free_s);

            if (busy_q >= peak && busy_q != '0) begin
                peak  <= busy_q;
                pt    <= PEAK_LOAD;
                state <= HOLD;
            end else begin
                case (state)
                    HOLD: begin
                        if (pt == '0) begin
                            peak <= peak - 5'd1;
                            pt   <= PEAK_LOAD;
                            if (peak == 5'd1) state <= IDLE;
                        end else begin
                            pt <= pt - PW'(1);
                        end
                    end
                    default: ;
                endcase
            end

            if (steal_now) begin
                steal_cnt <= HOLD_LOAD;
            end else if (steal_cnt != '0) begin
                steal_cnt <= steal_cnt - HW'(1);
            end

            rled_q <= {bar_next, steal_next};
        end
    end

    assign bus.gled     = gled_q;
    assign bus.rled     = rled_q;
    assign bus.busy_cnt = busy_q;
    assign bus.steal    = rled_q[0];

endmodule

// File: tb/tb_led_activity_meter.sv
// Scoreboard bench for led_activity_meter: a time-history reference model
// predicts every output cycle, a negedge monitor compares against the DUT.
module tb_led_activity_meter;
    localparam int V    = 4;
    localparam int H    = 8;
    localparam int P    = 16;
    localparam int MAXT = 8192;

    logic sysclk = 1'b0;
    logic reset1 = 1'b0;

    led_activity_meter_if #(.VOICES(V)) ifc ();

    led_activity_meter #(
        .VOICES(V), .HOLD_TICKS(H), .PEAK_TICKS(P)
    ) dut (
        .sysclk (sysclk),
        .reset1 (reset1),
        .bus    (ifc)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [7:0]  gled;
        logic [16:0] rled;
        logic [4:0]  busy;
        logic        steal;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Input history indexed by the count of active (out-of-reset) edges
    logic [V-1:0] k_hist [MAXT];
    logic [V-1:0] f_hist [MAXT];
    int           b_hist [MAXT];
    int           pk_hist[MAXT];
    int           t = 0;
    int           epoch = 0;
    bit           in_rst = 1'b1;
    int           last_rise[V];
    int           last_steal;
    int           ls, vs;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Key level the design logic sees at active edge x (two synchronizer edges late)
    function automatic logic [V-1:0] sync_keys(input int x);
        return (x - 2 >= epoch) ? k_hist[x-2] : '0;
    endfunction

    function automatic logic [V-1:0] sync_free(input int x);
        return (x - 2 >= epoch) ? f_hist[x-2] : '1;
    endfunction

    always @(posedge sysclk) begin
        logic [V-1:0] s_now, rz;
        int           bprev, pkprev, pk;
        exp_t         e;
        if (!reset1) begin
            in_rst = 1'b1;
        end else if (t < MAXT) begin
            if (in_rst) begin
                in_rst = 1'b0;
                epoch  = t;
                for (int v = 0; v < V; v++) last_rise[v] = -100000;
                last_steal = -100000;
                ls = 0;
                vs = 0;
            end
            k_hist[t] = ifc.keys_on;
            f_hist[t] = ifc.voice_free;
            s_now  = sync_keys(t);
            rz     = s_now & ~sync_keys(t - 1);
            bprev  = (t - 1 >= epoch) ? b_hist[t-1]  : 0;
            pkprev = (t - 1 >= epoch) ? pk_hist[t-1] : 0;
            for (int v = 0; v < V; v++) if (rz[v]) last_rise[v] = t;
            if (rz != '0 && bprev == V) last_steal = t;
            if (bprev > 0 && bprev >= pkprev) begin
                ls = t;
                vs = bprev;
            end
            pk = vs - (t - ls) / P;
            if (pk < 0) pk = 0;
            b_hist[t]  = $countones(~sync_free(t));
            pk_hist[t] = pk;

            e.gled = '0;
            for (int v = 0; v < V; v++) e.gled[v] = s_now[v] | ((t - last_rise[v]) < H);
            e.rled = '0;
            e.rled[0] = (t - last_steal) < H;
            for (int i = 1; i <= 16; i++) e.rled[i] = (i <= bprev) || (i == pkprev);
            e.busy  = 5'(b_hist[t]);
            e.steal = e.rled[0];
            sb.push_back(e);
            t++;
        end
    end

    exp_t m;
    always @(negedge sysclk) begin
        if (!reset1) begin
            sb.delete();
        end else if (sb.size() > 0) begin
            m = sb.pop_front();
            chk("gled",     32'(ifc.gled),     32'(m.gled));
            chk("rled",     32'(ifc.rled),     32'(m.rled));
            chk("busy_cnt", 32'(ifc.busy_cnt), 32'(m.busy));
            chk("steal",    32'(ifc.steal),    32'(m.steal));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sysclk);
            #2;
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_gled"},  32'(ifc.gled),     32'd0);
        chk({nm, "_rled"},  32'(ifc.rled),     32'd0);
        chk({nm, "_busy"},  32'(ifc.busy_cnt), 32'd0);
        chk({nm, "_steal"}, 32'(ifc.steal),    32'd0);
    endtask

    initial begin
        ifc.keys_on    = '0;
        ifc.voice_free = '1;

        // Reset held with random activity on the inputs
        for (int n = 0; n < 6; n++) begin
            ifc.keys_on    = V'($urandom_range(0, 15));
            ifc.voice_free = V'($urandom_range(0, 15));
            tick(1);
            chk_zero("in_reset");
        end
        ifc.keys_on    = '0;
        ifc.voice_free = '1;
        tick(1);
        reset1 = 1'b1;
        tick(10);

        // Short note on voice 1
        ifc.keys_on = 4'b0010;
        tick(2);
        ifc.keys_on = '0;
        tick(15);

        // Long note on voice 0, then retrigger during the residual hold
        ifc.keys_on = 4'b0001;
        tick(20);
        ifc.keys_on = '0;
        tick(3);
        ifc.keys_on = 4'b0001;
        tick(2);
        ifc.keys_on = '0;
        tick(15);

        // Full occupancy burst, then peak decay
        ifc.voice_free = 4'h0;
        tick(5);
        ifc.voice_free = 4'hF;
        tick(80);

        // Steal at full occupancy, then the same key with one voice free
        ifc.voice_free = 4'h0;
        tick(6);
        ifc.keys_on = 4'b0100;
        tick(3);
        ifc.keys_on = '0;
        tick(12);
        ifc.voice_free = 4'b0001;
        tick(6);
        ifc.keys_on = 4'b0100;
        tick(3);
        ifc.keys_on = '0;
        tick(12);
        ifc.voice_free = 4'hF;
        tick(70);

        // Reset three cycles into a hold
        ifc.keys_on = 4'b0010;
        tick(2);
        ifc.keys_on = '0;
        tick(3);
        chk("pre_reset_gled1", 32'(ifc.gled[1]), 32'd1);
        reset1 = 1'b0;
        #1;
        chk_zero("mid_hold_reset");
        tick(3);
        chk_zero("mid_hold_reset_held");
        reset1 = 1'b1;
        tick(20);

        // Randomized traffic, biased toward full occupancy to provoke steals
        for (int n = 0; n < 150; n++) begin
            ifc.keys_on = V'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                ifc.voice_free = ($urandom_range(0, 2) == 0) ? 4'h0 : V'($urandom_range(0, 15));
            end
            tick($urandom_range(1, 10));
        end
        ifc.keys_on    = '0;
        ifc.voice_free = '1;
        tick(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
